// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer: FSM states,
// register-bank geometry and the default identification word.
package apb_pkg;

    localparam int          NUM_REGS         = 8;
    localparam int          IDX_W            = 3;
    localparam logic [2:0]  REG_ID           = 3'd0;
    localparam logic [2:0]  REG_CTRL         = 3'd1;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA0B0_0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master side) and one completer.
interface apb_slave_regfile_if;

    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_regbank.sv
// Eight-entry 32-bit register bank. Entry 0 is a constant ID word and is
// never stored; entries 1..7 are writable. Entry 1 is tapped out as the
// control word for downstream logic.
module apb_regbank
    import apb_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [31:0]       wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [31:0]       rdata,
    output logic [31:0]       reg_ctrl
);

    logic [31:0] store [1:NUM_REGS-1];

    // Writable storage; writes aimed at the ID slot have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                store[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (widx == IDX_W'(i)) begin
                    store[i] <= wdata;
                end
            end
        end
    end

    // Combinational read port, ID constant substituted for entry 0.
    always_comb begin
        rdata = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = store[i];
            end
        end
    end

    assign reg_ctrl = store[REG_CTRL];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer for one Pselx slot: decodes the access, inserts a
// programmable number of wait states, answers with data or an error and
// commits writes into the register bank at the completing cycle.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          SEL_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                Hclk,
    input  logic                Hreset,
    apb_slave_regfile_if.slave  bus,
    output logic [31:0]         Reg_ctrl
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic             sel;
    logic             setup_ph;
    logic             access_ph;
    logic [31:0]      off;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             err;
    logic             unused_sel;

    logic [31:0]      bank_rdata;
    logic             commit;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_d;
    logic             slverr_d;
    logic [31:0]      prdata_d;

    assign sel        = bus.Pselx[SEL_IDX];
    assign setup_ph   = sel & ~bus.Penable;
    assign access_ph  = sel & bus.Penable;
    assign unused_sel = ^bus.Pselx;

    assign off = bus.Paddr - BASE_ADDR;
    assign hit = (off < 32'd32) && (bus.Paddr[1:0] == 2'b00);
    assign idx = off[4:2];
    assign err = ~hit | (bus.Pwrite & (idx == REG_ID));

    apb_regbank #(
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk      (Hclk),
        .rst      (Hreset),
        .we       (commit),
        .widx     (idx_q),
        .wdata    (wdata_q),
        .ridx     (idx),
        .rdata    (bank_rdata),
        .reg_ctrl (Reg_ctrl)
    );

    // Next-state logic: capture on setup, count wait states, and prepare
    // the registered response so it is valid in the completing cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        err_d    = err_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        prdata_d = '0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup_ph) begin
                    wr_d    = bus.Pwrite;
                    err_d   = err;
                    idx_d   = idx;
                    wdata_d = bus.Pwdata;
                    rdata_d = (!bus.Pwrite && hit) ? bank_rdata : 32'd0;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        state_d  = ACCESS;
                        ready_d  = 1'b1;
                        slverr_d = err;
                        prdata_d = rdata_d;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!access_ph) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    ready_d  = 1'b1;
                    slverr_d = err_q;
                    prdata_d = rdata_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                commit  = access_ph & wr_q & ~err_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transfer context and registered response outputs.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus.Pready  <= 1'b0;
            bus.Pslverr <= 1'b0;
            bus.Prdata  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus.Pready  <= ready_d;
            bus.Pslverr <= slverr_d;
            bus.Prdata  <= prdata_d;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: three completers on one APB bus (slot 0 with no
// wait states, slot 1 with three, slot 2 with two) compared against an
// array-based model of the register banks.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] IDV  = 32'hA0B0_0001;
    localparam int          WS0  = 0;
    localparam int          WS1  = 3;
    localparam int          WS2  = 2;

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] ctrl0, ctrl1, ctrl2;

    int check_count;
    int pass_count;

    logic [31:0] model [3][8];

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus1 ();
    apb_slave_regfile_if bus2 ();

    assign bus0.Pselx = pselx;  assign bus0.Penable = penable;  assign bus0.Pwrite = pwrite;
    assign bus0.Paddr = paddr;  assign bus0.Pwdata  = pwdata;
    assign bus1.Pselx = pselx;  assign bus1.Penable = penable;  assign bus1.Pwrite = pwrite;
    assign bus1.Paddr = paddr;  assign bus1.Pwdata  = pwdata;
    assign bus2.Pselx = pselx;  assign bus2.Penable = penable;  assign bus2.Pwrite = pwrite;
    assign bus2.Paddr = paddr;  assign bus2.Pwdata  = pwdata;

    apb_slave_regfile #(.SEL_IDX(0), .BASE_ADDR(BASE), .WAIT_STATES(WS0), .ID_VALUE(IDV)) dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus0), .Reg_ctrl(ctrl0));
    apb_slave_regfile #(.SEL_IDX(1), .BASE_ADDR(BASE), .WAIT_STATES(WS1), .ID_VALUE(IDV)) dut1 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus1), .Reg_ctrl(ctrl1));
    apb_slave_regfile #(.SEL_IDX(2), .BASE_ADDR(BASE), .WAIT_STATES(WS2), .ID_VALUE(IDV)) dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus2), .Reg_ctrl(ctrl2));

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    function automatic int ws_of(input int s);
        if (s == 0) return WS0;
        else if (s == 1) return WS1;
        else return WS2;
    endfunction

    function automatic logic get_ready(input int s);
        if (s == 0) return bus0.Pready;
        else if (s == 1) return bus1.Pready;
        else return bus2.Pready;
    endfunction

    function automatic logic get_slverr(input int s);
        if (s == 0) return bus0.Pslverr;
        else if (s == 1) return bus1.Pslverr;
        else return bus2.Pslverr;
    endfunction

    function automatic logic [31:0] get_prdata(input int s);
        if (s == 0) return bus0.Prdata;
        else if (s == 1) return bus1.Prdata;
        else return bus2.Prdata;
    endfunction

    function automatic logic [31:0] get_ctrl(input int s);
        if (s == 0) return ctrl0;
        else if (s == 1) return ctrl1;
        else return ctrl2;
    endfunction

    task automatic resetModel();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                model[s][i] = (i == 0) ? IDV : 32'd0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One APB transfer to slot s. abort_at > 0 drops the select in that
    // access cycle. idle_after inserts an idle bus cycle after completion.
    task automatic applyStimulus(input int s, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int abort_at, input bit idle_after);
        logic [31:0] offs;
        logic        hit;
        int          ridx;
        logic        err;
        logic [31:0] exp_rdata;
        int          exp_cycle;
        int          seen;
        int          n;
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] got_ctrl;

        offs      = addr - BASE;
        hit       = (offs < 32) && (addr % 4 == 0);
        ridx      = int'(offs / 4) % 8;
        err       = !hit || (wr && ridx == 0);
        exp_rdata = (!wr && hit) ? model[s][ridx] : 32'd0;
        exp_cycle = (abort_at != 0) ? 0 : ws_of(s) + 1;

        pselx   = 3'(1 << s);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge Hclk);
        checkOutput("setup_ready", 32'(get_ready(s)), 32'd0);
        checkOutput("setup_ctrl", get_ctrl(s), model[s][1]);
        @(posedge Hclk); #1;
        penable   = 1'b1;
        seen      = 0;
        n         = 1;
        got_rdata = '0;
        got_err   = 1'b0;
        got_ctrl  = '0;
        while (seen == 0 && n <= 20 && !(abort_at != 0 && n > abort_at + 3)) begin
            if (n == abort_at) begin
                pselx   = 3'b000;
                penable = 1'b0;
            end
            @(negedge Hclk);
            if (get_ready(s)) begin
                seen      = n;
                got_rdata = get_prdata(s);
                got_err   = get_slverr(s);
                got_ctrl  = get_ctrl(s);
            end
            @(posedge Hclk); #1;
            n++;
        end
        checkOutput("ready_cycle", 32'(seen), 32'(exp_cycle));
        if (seen != 0) begin
            checkOutput("slverr", 32'(got_err), 32'(err));
            checkOutput("prdata", got_rdata, exp_rdata);
            checkOutput("ctrl_not_early", got_ctrl, model[s][1]);
            if (wr && !err) model[s][ridx] = wdata;
        end
        if (idle_after || abort_at != 0) begin
            pselx   = 3'b000;
            penable = 1'b0;
            @(posedge Hclk); #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        check_count = 0;
        pass_count  = 0;
        pselx   = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        Hreset  = 1'b1;
        resetModel();
        $display("[TB] start");

        // Reset: two cycles held, then everything quiet.
        @(posedge Hclk); @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(negedge Hclk);
        for (int s = 0; s < 3; s++) begin
            checkOutput("rst_prdata", get_prdata(s), 32'd0);
            checkOutput("rst_pready", 32'(get_ready(s)), 32'd0);
            checkOutput("rst_pslverr", 32'(get_slverr(s)), 32'd0);
            checkOutput("rst_ctrl", get_ctrl(s), 32'd0);
        end
        @(posedge Hclk); #1;

        // ID read, then write/read of the control register.
        applyStimulus(0, 1'b0, BASE, 32'd0, 0, 1'b1);
        applyStimulus(0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 0, 1'b1);
        applyStimulus(0, 1'b0, BASE + 32'h4, 32'd0, 0, 1'b1);

        // Wait-state slot.
        applyStimulus(1, 1'b1, BASE + 32'h8, 32'h0BAD_F00D, 0, 1'b1);
        applyStimulus(1, 1'b0, BASE + 32'h8, 32'd0, 0, 1'b1);
        applyStimulus(1, 1'b1, BASE + 32'h4, 32'h1111_2222, 0, 1'b1);
        applyStimulus(1, 1'b0, BASE + 32'h4, 32'd0, 0, 1'b1);

        // Error responses.
        applyStimulus(0, 1'b1, BASE, 32'h0000_1234, 0, 1'b1);
        applyStimulus(0, 1'b0, BASE, 32'd0, 0, 1'b1);
        applyStimulus(0, 1'b0, BASE + 32'h20, 32'd0, 0, 1'b1);
        applyStimulus(0, 1'b0, BASE + 32'h6, 32'd0, 0, 1'b1);
        applyStimulus(2, 1'b0, BASE + 32'h20, 32'd0, 0, 1'b1);

        // Abort in the second access cycle.
        applyStimulus(2, 1'b1, BASE + 32'hC, 32'h5555_5555, 2, 1'b1);
        applyStimulus(2, 1'b0, BASE + 32'hC, 32'd0, 0, 1'b1);

        // Back-to-back with no idle cycles.
        applyStimulus(0, 1'b1, BASE + 32'h10, 32'h4444_0004, 0, 1'b0);
        applyStimulus(0, 1'b1, BASE + 32'h14, 32'h5555_0005, 0, 1'b0);
        applyStimulus(0, 1'b0, BASE + 32'h10, 32'd0, 0, 1'b0);
        applyStimulus(0, 1'b0, BASE + 32'h14, 32'd0, 0, 1'b1);

        // Randomized traffic across all three slots.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 44));
            applyStimulus(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), a, $urandom, 0,
                          1'($urandom_range(0, 1)));
        end

        // Reset during the wait phase of a write to register 6 on slot 1;
        // the bus keeps the access phase up so only reset can stop it.
        pselx   = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h18;
        pwdata  = 32'hCAFE_F00D;
        @(posedge Hclk); #1;
        penable = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        resetModel();
        for (int c = 0; c < 4; c++) begin
            @(negedge Hclk);
            checkOutput("midrst_pready", 32'(get_ready(1)), 32'd0);
            checkOutput("midrst_prdata", get_prdata(1), 32'd0);
            checkOutput("midrst_pslverr", 32'(get_slverr(1)), 32'd0);
            checkOutput("midrst_ctrl", get_ctrl(1), 32'd0);
            @(posedge Hclk); #1;
        end
        pselx   = 3'b000;
        penable = 1'b0;
        @(posedge Hclk); #1;
        applyStimulus(1, 1'b0, BASE + 32'h18, 32'd0, 0, 1'b1);

        // Final sweep of every register in every slot.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(s, 1'b0, BASE + 32'(4 * i), 32'd0, 0, 1'b0);
            end
        end
        pselx   = 3'b000;
        penable = 1'b0;
        @(posedge Hclk); #1;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
